rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_ctrl_pkg.sv | 33 +++
 rtl/rx_frame_ctrl_frame_buf.sv | 45 ++++
 rtl/rx_frame_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rx_frame_ctrl_pkg
// Shared definitions for the receive-frame controller:
//   - rx_state_t      : frame FSM state encoding
//   - FRAME_SOF       : start-of-frame marker byte
//   - ERR_*           : err_code values reported with frame_err
//   - chk_accumulate  : running checksum fold (XOR of ADDR, LEN, payload)
// ---------------------------------------------------------------------------
package rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_LEN  = 3'd2,
        ST_GET_DATA = 3'd3,
        ST_GET_CHK  = 3'd4,
        ST_COMMIT   = 3'd5
    } rx_state_t;

    localparam logic [7:0] FRAME_SOF = 8'hAA;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    // Fold one byte into the running frame checksum.
    function automatic logic [7:0] chk_accumulate(input logic [7:0] acc,
                                                  input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

endpackage

// File: rtl/rx_frame_ctrl_frame_buf.sv
// ---------------------------------------------------------------------------
// frame_buf
// Payload buffer, DEPTH x 8. One synchronous write port, one combinational
// read port. Indices at or beyond DEPTH are ignored on write and read as 0.
// Ports:
//   clk      : rising-edge clock
//   wr_en    : write strobe
//   wr_idx   : write index
//   wr_data  : write byte
//   rd_idx   : read index
//   rd_data  : byte at rd_idx
// ---------------------------------------------------------------------------
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] mem_r [DEPTH];

    // Storage write; contents are not reset, a new frame always overwrites
    // every entry it later reads.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_idx) < DEPTH)) begin
            mem_r[wr_idx[AW-1:0]] <= wr_data;
        end
    end

    // Combinational read with out-of-range guard.
    always_comb begin
        if (int'(rd_idx) < DEPTH) begin
            rd_data = mem_r[rd_idx[AW-1:0]];
        end else begin
            rd_data = 8'h00;
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rx_frame_ctrl
// Parses frames "AA ADDR LEN payload[LEN] CHK" from a byte stream, checks
// length and XOR checksum, then replays the payload as register writes
// (ADDR+i, payload[i]) over a valid/ready write port.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   rx_data, rx_valid : received byte and its one-cycle strobe
//   wr_valid/addr/data: write request, held stable until wr_ready
//   wr_ready          : write accepted when high with wr_valid
//   frame_done        : one-cycle pulse after the last write of a frame
//   frame_err         : one-cycle pulse on an aborted frame
//   err_code          : abort cause (1 length, 2 checksum, 3 timeout), held
//   busy              : high whenever the FSM is outside IDLE
// ---------------------------------------------------------------------------
module rx_frame_ctrl
    import rx_frame_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 52080,
    parameter int MAX_LEN      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    // Index/length counters must hold the value MAX_LEN itself.
    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);

    rx_state_t        state_r;
    logic [7:0]       addr_r;
    logic [IDX_W-1:0] len_r;
    logic [7:0]       chk_r;
    logic [IDX_W-1:0] idx_r;      // payload store index, then commit counter
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             wr_valid_r;
    logic [7:0]       wr_addr_r;
    logic [7:0]       wr_data_r;
    logic             frame_done_r;
    logic             frame_err_r;
    logic [1:0]       err_code_r;
    logic             busy_r;

    logic             in_rx_s;
    logic             tmo_hit_s;
    logic             buf_we_s;
    logic [7:0]       buf_rd_data_s;

    assign in_rx_s   = (state_r == ST_GET_ADDR) || (state_r == ST_GET_LEN) ||
                       (state_r == ST_GET_DATA) || (state_r == ST_GET_CHK);
    // A byte on the expiry cycle wins over the timeout.
    assign tmo_hit_s = in_rx_s && !rx_valid && (tmo_cnt_r == TMO_LAST);
    assign buf_we_s  = rx_valid && (state_r == ST_GET_DATA);

    // During commit idx_r points at the next entry to present, so the read
    // port already holds the byte needed on the next handshake.
    frame_buf #(
        .DEPTH (MAX_LEN),
        .IDX_W (IDX_W)
    ) u_frame_buf (
        .clk     (clk),
        .wr_en   (buf_we_s),
        .wr_idx  (idx_r),
        .wr_data (rx_data),
        .rd_idx  (idx_r),
        .rd_data (buf_rd_data_s)
    );

    // Frame FSM: header capture, payload store, checksum check, write replay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= 8'h00;
            len_r        <= {IDX_W{1'b0}};
            chk_r        <= 8'h00;
            idx_r        <= {IDX_W{1'b0}};
            tmo_cnt_r    <= {TMO_W{1'b0}};
            wr_valid_r   <= 1'b0;
            wr_addr_r    <= 8'h00;
            wr_data_r    <= 8'h00;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            err_code_r   <= ERR_NONE;
            busy_r       <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (tmo_hit_s) begin
                frame_err_r <= 1'b1;
                err_code_r  <= ERR_TIMEOUT;
                state_r     <= ST_IDLE;
                busy_r      <= 1'b0;
                tmo_cnt_r   <= {TMO_W{1'b0}};
            end else begin
                if (in_rx_s && !rx_valid) begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                end else begin
                    tmo_cnt_r <= {TMO_W{1'b0}};
                end
                case (state_r)
                    ST_IDLE: begin
                        if (rx_valid && (rx_data == FRAME_SOF)) begin
                            state_r <= ST_GET_ADDR;
                            busy_r  <= 1'b1;
                        end
                    end
                    ST_GET_ADDR: begin
                        if (rx_valid) begin
                            addr_r  <= rx_data;
                            chk_r   <= rx_data;
                            state_r <= ST_GET_LEN;
                        end
                    end
                    ST_GET_LEN: begin
                        if (rx_valid) begin
                            if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
                                frame_err_r <= 1'b1;
                                err_code_r  <= ERR_BAD_LEN;
                                state_r     <= ST_IDLE;
                                busy_r      <= 1'b0;
                            end else begin
                                len_r   <= IDX_W'(rx_data);
                                chk_r   <= chk_accumulate(chk_r, rx_data);
                                idx_r   <= {IDX_W{1'b0}};
                                state_r <= ST_GET_DATA;
                            end
                        end
                    end
                    ST_GET_DATA: begin
                        if (rx_valid) begin
                            chk_r <= chk_accumulate(chk_r, rx_data);
                            if ((idx_r + IDX_W'(1)) == len_r) begin
                                idx_r   <= {IDX_W{1'b0}};
                                state_r <= ST_GET_CHK;
                            end else begin
                                idx_r <= idx_r + IDX_W'(1);
                            end
                        end
                    end
                    ST_GET_CHK: begin
                        if (rx_valid) begin
                            if (rx_data != chk_r) begin
                                frame_err_r <= 1'b1;
                                err_code_r  <= ERR_CHECKSUM;
                                state_r     <= ST_IDLE;
                                busy_r      <= 1'b0;
                            end else begin
                                // Present entry 0 immediately; idx_r moves to 1.
                                wr_valid_r <= 1'b1;
                                wr_addr_r  <= addr_r;
                                wr_data_r  <= buf_rd_data_s;
                                idx_r      <= IDX_W'(1);
                                state_r    <= ST_COMMIT;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        // Incoming bytes are dropped here by design.
                        if (wr_valid_r && wr_ready) begin
                            if (idx_r == len_r) begin
                                wr_valid_r   <= 1'b0;
                                frame_done_r <= 1'b1;
                                state_r      <= ST_IDLE;
                                busy_r       <= 1'b0;
                            end else begin
                                wr_addr_r <= wr_addr_r + 8'd1;
                                wr_data_r <= buf_rd_data_s;
                                idx_r     <= idx_r + IDX_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        wr_valid_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_valid   = wr_valid_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign err_code   = err_code_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_ctrl
// Self-checking bench for rx_frame_ctrl. Frames are built from byte lists;
// a frame-level reference (length rule, XOR checksum, address wrap) predicts
// the write list and done/error events, which a negedge monitor collects
// from the DUT.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_frame_ctrl;
    localparam int TMO  = 64;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       wr_ready = 1'b0;
    logic       wr_valid, frame_done, frame_err, busy;
    logic [7:0] wr_addr, wr_data;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_obs_q[$];
    logic [15:0] exp_wr_q[$];
    int          ev_q[$];       // 0 = done, 1..3 = error code
    int          exp_ev_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  pl_q[$];
    int          both_cnt = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_ad = 16'h0000;
    bit          rnd_ready = 1'b0;

    rx_frame_ctrl #(.TIMEOUT_CLKS(TMO), .MAX_LEN(MAXL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Monitor: record handshakes and pulses, and watch stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid && wr_ready) wr_obs_q.push_back({wr_addr, wr_data});
            if (frame_done) ev_q.push_back(0);
            if (frame_err) ev_q.push_back(int'(err_code));
            if (frame_done && frame_err) both_cnt <= both_cnt + 1;
            if (prev_stall && (!wr_valid || ({wr_addr, wr_data} != prev_ad)))
                stall_viol <= stall_viol + 1;
        end
        prev_stall <= rst_n && wr_valid && !wr_ready;
        prev_ad    <= {wr_addr, wr_data};
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) wr_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_obs();
        wr_obs_q.delete(); exp_wr_q.delete(); ev_q.delete(); exp_ev_q.delete();
    endtask

    task automatic send_bytes(input int maxgap);
        int g;
        foreach (tx_q[i]) begin
            rx_data = tx_q[i]; rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0; rx_data = 8'($urandom);
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            idle(g);
        end
        tx_q.delete();
    endtask

    // Reference: outcome of one complete frame (payload taken from pl_q).
    task automatic model_frame(input logic [7:0] addr, input int len, input logic [7:0] chk);
        logic [7:0] x;
        if (len == 0 || len > MAXL) begin
            exp_ev_q.push_back(1);
        end else begin
            x = addr ^ 8'(len);
            foreach (pl_q[i]) x = x ^ pl_q[i];
            if (x != chk) begin
                exp_ev_q.push_back(2);
            end else begin
                for (int i = 0; i < len; i++) exp_wr_q.push_back({8'(int'(addr) + i), pl_q[i]});
                exp_ev_q.push_back(0);
            end
        end
    endtask

    // Queue frame bytes; a bad length stops the frame after LEN.
    task automatic queue_frame(input logic [7:0] addr, input int len, input logic [7:0] chk);
        tx_q.push_back(8'hAA); tx_q.push_back(addr); tx_q.push_back(8'(len));
        if (len != 0 && len <= MAXL) begin
            foreach (pl_q[i]) tx_q.push_back(pl_q[i]);
            tx_q.push_back(chk);
        end
        model_frame(addr, len, chk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin tick(); n++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_wait: busy=%b after %0d cycles, required 0", name, busy, n);
        end
        idle(2);
    endtask

    function automatic int wr_diff();
        int n = (wr_obs_q.size() > exp_wr_q.size()) ? wr_obs_q.size() : exp_wr_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= wr_obs_q.size() || i >= exp_wr_q.size()) return i;
            if (wr_obs_q[i] !== exp_wr_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic int ev_diff();
        int n = (ev_q.size() > exp_ev_q.size()) ? ev_q.size() : exp_ev_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= ev_q.size() || i >= exp_ev_q.size()) return i;
            if (ev_q[i] != exp_ev_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] obs_at(input int i);
        return (i >= 0 && i < wr_obs_q.size()) ? wr_obs_q[i] : 16'hFFFF;
    endfunction

    function automatic logic [15:0] exp_at(input int i);
        return (i >= 0 && i < exp_wr_q.size()) ? exp_wr_q[i] : 16'hFFFF;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; idle(3);
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b required 0", wr_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d required 0", err_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        rst_n = 1'b1; idle(2);
    endtask

    task automatic test_normal();
        int d, n;
        clear_obs(); wr_ready = 1'b1;
        // XOR of 10,03,11,22,33 is 0x13.
        pl_q = '{8'h11, 8'h22, 8'h33};
        queue_frame(8'h10, 3, 8'h13);
        send_bytes(0);
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== 8'h10 || wr_data !== 8'h11 || busy !== 1'b1) begin
            errors++;
            $display("FAIL normal_first_write: valid=%b addr=%h data=%h busy=%b, required 1 10 11 1", wr_valid, wr_addr, wr_data, busy);
        end
        n = 0;
        while (frame_done !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (n != 3) begin errors++; $display("FAIL normal_done_latency: got %0d cycles required 3", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_busy_at_done: got %b required 0", busy); end
        idle(2);
        d = wr_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL normal_writes: #%0d got %h (n=%0d) required %h (n=%0d)", d, obs_at(d), wr_obs_q.size(), exp_at(d), exp_wr_q.size()); end
        d = ev_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL normal_events: got %0d events required %0d (diff at %0d)", ev_q.size(), exp_ev_q.size(), d); end
    endtask

    task automatic test_bad_chk();
        int d;
        clear_obs(); wr_ready = 1'b1;
        pl_q = '{8'h11, 8'h22, 8'h33};
        queue_frame(8'h10, 3, 8'h23); send_bytes(0); wait_idle("bad_chk_a");
        queue_frame(8'h10, 3, 8'h24); send_bytes(1); wait_idle("bad_chk_b");
        idle(5);
        d = wr_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL bad_chk_writes: got %0d writes required %0d", wr_obs_q.size(), exp_wr_q.size()); end
        d = ev_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL bad_chk_events: got %0d events required %0d (diff at %0d)", ev_q.size(), exp_ev_q.size(), d); end
        checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL bad_chk_err_hold: got %0d required 2", err_code); end
    endtask

    task automatic test_bad_len();
        int d;
        logic [7:0] x;
        clear_obs(); wr_ready = 1'b1;
        pl_q.delete();
        queue_frame(8'h10, 0, 8'h00); send_bytes(0); wait_idle("len_zero");
        queue_frame(8'h20, MAXL + 1, 8'h00); send_bytes(0); wait_idle("len_over");
        x = 8'hC0 ^ 8'(MAXL);
        for (int i = 0; i < MAXL; i++) begin pl_q.push_back(8'($urandom)); x = x ^ pl_q[i]; end
        queue_frame(8'hC0, MAXL, x); send_bytes(2); wait_idle("len_max");
        pl_q = '{8'h11, 8'h22, 8'h33};
        queue_frame(8'h10, 3, 8'h13); send_bytes(0); wait_idle("len_recover");
        d = wr_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL bad_len_writes: #%0d got %h (n=%0d) required %h (n=%0d)", d, obs_at(d), wr_obs_q.size(), exp_at(d), exp_wr_q.size()); end
        d = ev_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL bad_len_events: got %0d events required %0d (diff at %0d)", ev_q.size(), exp_ev_q.size(), d); end
    endtask

    task automatic test_timeout();
        int d;
        // Byte arriving on the expiry cycle wins.
        clear_obs(); wr_ready = 1'b1;
        tx_q = '{8'hAA, 8'h05}; send_bytes(0);
        idle(TMO - 1);
        tx_q = '{8'h01, 8'h5A, 8'h5E}; send_bytes(0);
        pl_q = '{8'h5A}; model_frame(8'h05, 1, 8'h5E);
        wait_idle("tmo_edge");
        d = wr_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL tmo_edge_writes: got %0d writes required %0d", wr_obs_q.size(), exp_wr_q.size()); end
        d = ev_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL tmo_edge_events: got %0d events required %0d (diff at %0d)", ev_q.size(), exp_ev_q.size(), d); end
        // Full gap: error exactly after TMO idle cycles.
        clear_obs();
        tx_q = '{8'hAA, 8'h05}; send_bytes(0);
        idle(TMO - 1);
        checks++; if (frame_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early: err=%b busy=%b required 0 1", frame_err, busy); end
        tick();
        checks++;
        if (frame_err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL tmo_fire: err=%b code=%0d busy=%b required 1 3 0", frame_err, err_code, busy);
        end
        idle(2);
        exp_ev_q.push_back(3);
        d = ev_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL tmo_events: got %0d events required %0d (diff at %0d)", ev_q.size(), exp_ev_q.size(), d); end
        // A long stall in commit never times out.
        clear_obs(); wr_ready = 1'b0;
        pl_q = '{8'hC3, 8'h3C};
        queue_frame(8'h7E, 2, 8'h7E ^ 8'h02 ^ 8'hC3 ^ 8'h3C); send_bytes(0);
        idle(TMO + 10);
        checks++; if (busy !== 1'b1 || wr_valid !== 1'b1) begin errors++; $display("FAIL commit_no_tmo: busy=%b wr_valid=%b required 1 1", busy, wr_valid); end
        wr_ready = 1'b1; wait_idle("commit_no_tmo");
        d = ev_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL commit_no_tmo_events: got %0d events required %0d (diff at %0d)", ev_q.size(), exp_ev_q.size(), d); end
    endtask

    task automatic test_backpressure_wrap();
        int d;
        bit ok = 1'b1;
        clear_obs(); wr_ready = 1'b0;
        stall_viol = 0;
        pl_q = '{8'h01, 8'h02};
        queue_frame(8'hFF, 2, 8'hFE); send_bytes(0);
        for (int i = 0; i < 5; i++) begin
            if (wr_valid !== 1'b1 || wr_addr !== 8'hFF || wr_data !== 8'h01) ok = 1'b0;
            tick();
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_stall_hold: last valid=%b addr=%h data=%h required 1 ff 01", wr_valid, wr_addr, wr_data); end
        wr_ready = 1'b1; wait_idle("bp");
        d = wr_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL bp_writes: #%0d got %h (n=%0d) required %h (n=%0d)", d, obs_at(d), wr_obs_q.size(), exp_at(d), exp_wr_q.size()); end
        d = ev_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL bp_events: got %0d events required %0d (diff at %0d)", ev_q.size(), exp_ev_q.size(), d); end
    endtask

    task automatic test_back_to_back();
        int d, n;
        clear_obs(); wr_ready = 1'b0;
        pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        queue_frame(8'h40, 4, 8'h40 ^ 8'h04 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF); send_bytes(0);
        // A whole frame sent during commit must be dropped.
        tx_q = '{8'hAA, 8'h40, 8'h01, 8'h55, 8'h14}; send_bytes(0);
        wr_ready = 1'b1;
        n = 0;
        while (frame_done !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (n != 4) begin errors++; $display("FAIL b2b_rate: got %0d cycles for 4 writes required 4", n); end
        wait_idle("b2b");
        idle(5);
        d = wr_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL b2b_writes: #%0d got %h (n=%0d) required %h (n=%0d)", d, obs_at(d), wr_obs_q.size(), exp_at(d), exp_wr_q.size()); end
        d = ev_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL b2b_events: got %0d events required %0d (diff at %0d)", ev_q.size(), exp_ev_q.size(), d); end
    endtask

    task automatic test_reset_commit();
        int d;
        clear_obs(); wr_ready = 1'b0;
        pl_q = '{8'h91, 8'h92, 8'h93};
        tx_q = '{8'hAA, 8'h30, 8'h03, 8'h91, 8'h92, 8'h93, 8'h30 ^ 8'h03 ^ 8'h91 ^ 8'h92 ^ 8'h93};
        send_bytes(0);
        // Only the first handshake may complete before reset.
        exp_wr_q.push_back({8'h30, 8'h91});
        wr_ready = 1'b1; tick();
        rst_n = 1'b0; idle(2);
        rst_n = 1'b1; idle(10);
        d = wr_diff(); checks++;
        if (d >= 0) begin errors++; $display("FAIL rst_commit_writes: got %0d writes required %0d", wr_obs_q.size(), exp_wr_q.size()); end
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL rst_commit_events: got %0d events required 0", ev_q.size()); end
        checks++; if (wr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_commit_idle: valid=%b busy=%b required 0 0", wr_valid, busy); end
    endtask

    task automatic test_random();
        int d, len, nj;
        logic [7:0] addr, x, b;
        rnd_ready = 1'b1;
        for (int f = 0; f < 12; f++) begin
            clear_obs();
            nj = int'($urandom_range(0, 3));
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom); if (b == 8'hAA) b = 8'h55;
                tx_q.push_back(b);
            end
            addr = 8'($urandom);
            len  = int'($urandom_range(0, MAXL + 2));
            pl_q.delete();
            x = addr ^ 8'(len);
            for (int i = 0; i < len; i++) begin b = 8'($urandom); pl_q.push_back(b); x = x ^ b; end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            queue_frame(addr, len, x);
            send_bytes(3);
            wait_idle("random");
            d = wr_diff(); checks++;
            if (d >= 0) begin errors++; $display("FAIL random_writes f%0d: #%0d got %h (n=%0d) required %h (n=%0d)", f, d, obs_at(d), wr_obs_q.size(), exp_at(d), exp_wr_q.size()); end
            d = ev_diff(); checks++;
            if (d >= 0) begin errors++; $display("FAIL random_events f%0d: got %0d events required %0d (diff at %0d)", f, ev_q.size(), exp_ev_q.size(), d); end
        end
        rnd_ready = 1'b0; wr_ready = 1'b0;
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL done_err_overlap: got %0d required 0", both_cnt); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stability: got %0d violations required 0", stall_viol); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_chk();
        test_bad_len();
        test_timeout();
        test_backpressure_wrap();
        test_back_to_back();
        test_reset_commit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
